// File: rtl/pipe_stall_regs_pkg.sv
// Shared constants and types for the PC / IF/ID / ID/EX register slice.
package pipe_stall_regs_pkg;

  localparam int          REG_W     = 5;
  localparam int          RS1_LSB   = 15;
  localparam int          RS2_LSB   = 20;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  // ID/EX control payload; valid marks a real instruction rather than a bubble.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             memread;
    logic             memwrite;
    logic             regwrite;
    logic             valid;
  } idex_t;

endpackage

// File: rtl/pipe_stall_regs_pipe_reg.sv
// Generic pipeline register: async reset value, synchronous clear-to-value, load enable.
module pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] clr_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= RST_VAL;
    else if (clr) q <= clr_val;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/pipe_stall_regs.sv
// PC, IF/ID and ID/EX registers driven by the hazard unit and the EX-stage branch flush.
module pipe_stall_regs
  import pipe_stall_regs_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             ifid_write,
  input  logic             stall,
  input  logic             flush,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [31:0]      imem_instr,
  input  logic [4:0]       id_rd,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_regwrite,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  ifid_pc,
  output logic [31:0]      ifid_instr,
  output logic             ifid_valid,
  output logic [4:0]       ifid_rs1,
  output logic [4:0]       ifid_rs2,
  output logic [4:0]       indec_rd,
  output logic             indec_memread,
  output logic             indec_memwrite,
  output logic             indec_regwrite,
  output logic             indec_valid,
  output logic [CNT_W-1:0] stall_count
);

  localparam int              IFID_W     = XLEN + 33;
  localparam logic [IFID_W-1:0] IFID_EMPTY = {{XLEN{1'b0}}, NOP_INSTR, 1'b0};

  // PC: flush redirect wins over sequential advance.
  pipe_reg #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc (
    .clk     (clk),
    .rst     (rst),
    .en      (pc_write),
    .clr     (flush),
    .clr_val (branch_target),
    .d       (pc_out + XLEN'(4)),
    .q       (pc_out)
  );

  logic [IFID_W-1:0] ifid_q;

  pipe_reg #(.W(IFID_W), .RST_VAL(IFID_EMPTY)) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .en      (ifid_write),
    .clr     (flush),
    .clr_val (IFID_EMPTY),
    .d       ({pc_out, imem_instr, 1'b1}),
    .q       (ifid_q)
  );

  assign {ifid_pc, ifid_instr, ifid_valid} = ifid_q;
  assign ifid_rs1 = ifid_valid ? ifid_instr[RS1_LSB +: REG_W] : '0;
  assign ifid_rs2 = ifid_valid ? ifid_instr[RS2_LSB +: REG_W] : '0;

  // A bubble in IF/ID must not carry decoded control into EX.
  idex_t idex_d;
  idex_t idex_q;

  always_comb begin
    idex_d = '0;
    if (ifid_valid) begin
      idex_d.rd       = id_rd;
      idex_d.memread  = id_memread;
      idex_d.memwrite = id_memwrite;
      idex_d.regwrite = id_regwrite;
      idex_d.valid    = 1'b1;
    end
  end

  pipe_reg #(.W($bits(idex_t)), .RST_VAL('0)) u_idex (
    .clk     (clk),
    .rst     (rst),
    .en      (1'b1),
    .clr     (flush | stall),
    .clr_val ('0),
    .d       (idex_d),
    .q       (idex_q)
  );

  assign indec_rd       = idex_q.rd;
  assign indec_memread  = idex_q.memread;
  assign indec_memwrite = idex_q.memwrite;
  assign indec_regwrite = idex_q.regwrite;
  assign indec_valid    = idex_q.valid;

  // Counts stall bubbles only; a flush in the same cycle means no bubble was due to stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (stall && !flush && (stall_count != '1))
      stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stall_regs.sv
// Self-checking bench for pipe_stall_regs: vector table, directed hazard sequences, random vs model.
module tb_pipe_stall_regs;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] LW_X5   = 32'h0002_A283;  // lw  x5, 0(x5)
  localparam logic [31:0] ADD_X6  = 32'h0032_8333;  // add x6, x5, x3

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, ifid_write, stall, flush;
  logic [31:0] branch_target;
  logic [31:0] imem_instr;
  logic [4:0]  id_rd;
  logic        id_memread, id_memwrite, id_regwrite;

  logic [31:0] pc_out, ifid_pc, ifid_instr;
  logic        ifid_valid;
  logic [4:0]  ifid_rs1, ifid_rs2, indec_rd;
  logic        indec_memread, indec_memwrite, indec_regwrite, indec_valid;
  logic [15:0] stall_count;

  logic [31:0] s_pc_out, s_ifid_pc, s_ifid_instr;
  logic        s_ifid_valid;
  logic [4:0]  s_ifid_rs1, s_ifid_rs2, s_indec_rd;
  logic        s_indec_memread, s_indec_memwrite, s_indec_regwrite, s_indec_valid;
  logic [1:0]  s_stall_count;

  logic        use_ovr;
  logic [31:0] ovr_instr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  assign imem_instr = use_ovr ? ovr_instr : imem_f(pc_out);

  pipe_stall_regs #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .ifid_write(ifid_write), .stall(stall),
    .flush(flush), .branch_target(branch_target), .imem_instr(imem_instr), .id_rd(id_rd),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_regwrite(id_regwrite),
    .pc_out(pc_out), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .indec_rd(indec_rd), .indec_memread(indec_memread),
    .indec_memwrite(indec_memwrite), .indec_regwrite(indec_regwrite), .indec_valid(indec_valid),
    .stall_count(stall_count)
  );

  // Narrow-counter copy sharing the same stimulus, used for the saturation check.
  pipe_stall_regs #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .pc_write(pc_write), .ifid_write(ifid_write), .stall(stall),
    .flush(flush), .branch_target(branch_target), .imem_instr(imem_instr), .id_rd(id_rd),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_regwrite(id_regwrite),
    .pc_out(s_pc_out), .ifid_pc(s_ifid_pc), .ifid_instr(s_ifid_instr), .ifid_valid(s_ifid_valid),
    .ifid_rs1(s_ifid_rs1), .ifid_rs2(s_ifid_rs2), .indec_rd(s_indec_rd),
    .indec_memread(s_indec_memread), .indec_memwrite(s_indec_memwrite),
    .indec_regwrite(s_indec_regwrite), .indec_valid(s_indec_valid),
    .stall_count(s_stall_count)
  );

  // Reference model state
  logic [31:0] m_pc, m_ifid_pc, m_ifid_instr;
  logic        m_ifid_v;
  logic [4:0]  m_ex_rd;
  logic        m_ex_mr, m_ex_mw, m_ex_rw, m_ex_v;
  int          m_cnt, m_cnt2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ifid_pc = 32'h0; m_ifid_instr = NOP; m_ifid_v = 1'b0;
    m_ex_rd = '0; m_ex_mr = 1'b0; m_ex_mw = 1'b0; m_ex_rw = 1'b0; m_ex_v = 1'b0;
    m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},         pc_out,         m_pc);
    check({tag, ".ifid_pc"},    ifid_pc,        m_ifid_pc);
    check({tag, ".ifid_instr"}, ifid_instr,     m_ifid_instr);
    check({tag, ".ifid_valid"}, ifid_valid,     m_ifid_v);
    check({tag, ".rs1"},        ifid_rs1,       m_ifid_v ? (m_ifid_instr >> 15) & 32'h1F : 32'h0);
    check({tag, ".rs2"},        ifid_rs2,       m_ifid_v ? (m_ifid_instr >> 20) & 32'h1F : 32'h0);
    check({tag, ".indec_rd"},   indec_rd,       m_ex_rd);
    check({tag, ".indec_mr"},   indec_memread,  m_ex_mr);
    check({tag, ".indec_mw"},   indec_memwrite, m_ex_mw);
    check({tag, ".indec_rw"},   indec_regwrite, m_ex_rw);
    check({tag, ".indec_v"},    indec_valid,    m_ex_v);
    check({tag, ".cnt"},        stall_count,    m_cnt);
    check({tag, ".cnt_sat"},    s_stall_count,  m_cnt2);
  endtask

  // One rising edge: next state derived from the behavioural rules, then everything compared.
  task automatic tick(input string tag);
    logic [31:0] fetched, n_pc, n_ipc, n_iin;
    logic        n_iv;
    logic [4:0]  n_rd;
    logic        n_mr, n_mw, n_rw, n_ev;
    fetched = use_ovr ? ovr_instr : imem_f(m_pc);
    if (flush)         n_pc = branch_target;
    else if (pc_write) n_pc = m_pc + 32'd4;
    else               n_pc = m_pc;
    if (flush)           begin n_ipc = 32'h0; n_iin = NOP;     n_iv = 1'b0; end
    else if (ifid_write) begin n_ipc = m_pc;  n_iin = fetched; n_iv = 1'b1; end
    else                 begin n_ipc = m_ifid_pc; n_iin = m_ifid_instr; n_iv = m_ifid_v; end
    if (flush || stall || !m_ifid_v) begin
      n_rd = '0; n_mr = 1'b0; n_mw = 1'b0; n_rw = 1'b0;
      n_ev = 1'b0;
    end else begin
      n_rd = id_rd; n_mr = id_memread; n_mw = id_memwrite; n_rw = id_regwrite;
      n_ev = 1'b1;
    end
    if (stall && !flush) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3)    m_cnt2++;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_ifid_pc = n_ipc; m_ifid_instr = n_iin; m_ifid_v = n_iv;
    m_ex_rd = n_rd; m_ex_mr = n_mr; m_ex_mw = n_mw; m_ex_rw = n_rw; m_ex_v = n_ev;
    check_all(tag);
  endtask

  task automatic set_ctl(input logic pw, input logic iw, input logic st, input logic fl);
    pc_write = pw; ifid_write = iw; stall = st; flush = fl;
  endtask

  // Asserted a couple of ns after an edge, i.e. mid-cycle; values must change at once.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    check({tag, ".pc_const"},    pc_out,     32'h0);
    check({tag, ".instr_const"}, ifid_instr, NOP);
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    #2;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        pw, iw, st, fl;
    logic [31:0] tgt;
    logic [31:0] e_pc, e_ifid_pc;
    logic        e_iv, e_ev;
    int          e_cnt;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic pw, iw, st, fl, input logic [31:0] tgt,
                              input logic [31:0] e_pc, e_ipc, input logic e_iv, e_ev,
                              input int e_cnt);
    vec_t v;
    v.pw = pw; v.iw = iw; v.st = st; v.fl = fl; v.tgt = tgt;
    v.e_pc = e_pc; v.e_ifid_pc = e_ipc; v.e_iv = e_iv; v.e_ev = e_ev; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    logic [31:0] r;

    rst = 1'b1; use_ovr = 1'b0; ovr_instr = NOP;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    branch_target = 32'h0; id_rd = '0; id_memread = 1'b0; id_memwrite = 1'b0; id_regwrite = 1'b0;
    model_reset();
    #12;
    rst = 1'b0;
    check_all("reset");

    //              pw    iw    st    fl    tgt     pc        ifid_pc   iv    ev    cnt
    vecs[0] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h004,  32'h000, 1'b1, 1'b0, 0);
    vecs[1] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h008,  32'h004, 1'b1, 1'b1, 0);
    vecs[2] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h00C,  32'h008, 1'b1, 1'b1, 0);
    vecs[3] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h00C,  32'h008, 1'b1, 1'b0, 1);
    vecs[4] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h010,  32'h00C, 1'b1, 1'b1, 1);
    vecs[5] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h100,  32'h000, 1'b0, 1'b0, 1);
    vecs[6] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h104,  32'h100, 1'b1, 1'b0, 1);
    vecs[7] = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   32'h108,  32'h104, 1'b1, 1'b0, 2);
    vecs[8] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h108,  32'h108, 1'b1, 1'b1, 2);
    vecs[9] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h10C,  32'h108, 1'b1, 1'b1, 2);

    for (int i = 0; i < 10; i++) begin
      set_ctl(vecs[i].pw, vecs[i].iw, vecs[i].st, vecs[i].fl);
      branch_target = vecs[i].tgt;
      id_rd = 5'(i + 1); id_memread = 1'b1; id_memwrite = 1'b0; id_regwrite = 1'b1;
      tick($sformatf("vec%0d", i));
      check($sformatf("vec%0d.pc_exp", i),      pc_out,      vecs[i].e_pc);
      check($sformatf("vec%0d.ifid_pc_exp", i), ifid_pc,     vecs[i].e_ifid_pc);
      check($sformatf("vec%0d.iv_exp", i),      ifid_valid,  vecs[i].e_iv);
      check($sformatf("vec%0d.ev_exp", i),      indec_valid, vecs[i].e_ev);
      check($sformatf("vec%0d.rd_exp", i),      indec_rd,    vecs[i].e_ev ? 32'(i + 1) : 32'h0);
      check($sformatf("vec%0d.instr_exp", i),   ifid_instr,
            vecs[i].e_iv ? imem_f(vecs[i].e_ifid_pc) : NOP);
      check($sformatf("vec%0d.cnt_exp", i),     stall_count, vecs[i].e_cnt);
    end

    // Reset asserted mid-cycle with live pipeline state
    async_reset("async_rst");

    // Free run from RESET_PC
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
    id_memread = 1'b0; id_regwrite = 1'b0; id_rd = '0;
    for (int i = 1; i <= 3; i++) begin
      tick("free");
      check("free.pc_step",   pc_out,  32'(4 * i));
      check("free.ifid_step", ifid_pc, 32'(4 * (i - 1)));
    end

    // Load-use: lw x5 into ID/EX, add x6,x5,x3 into IF/ID, then one stall edge
    use_ovr = 1'b1; ovr_instr = LW_X5;
    tick("lu_fetch_lw");
    ovr_instr = ADD_X6; id_rd = 5'd5; id_memread = 1'b1; id_regwrite = 1'b1;
    tick("lu_fetch_add");
    check("lu.pre_memread", indec_memread, 1'b1);
    check("lu.pre_rd",      indec_rd,      32'd5);
    check("lu.pre_rs1",     ifid_rs1,      32'd5);
    check("lu.pre_rs2",     ifid_rs2,      32'd3);
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
    ovr_instr = NOP; id_rd = 5'd6; id_memread = 1'b0;
    tick("lu_stall");
    check("lu.pc_hold",    pc_out,        32'h14);
    check("lu.instr_hold", ifid_instr,    ADD_X6);
    check("lu.memread",    indec_memread, 1'b0);
    check("lu.rd",         indec_rd,      32'h0);
    check("lu.cnt",        stall_count,   32'd1);
    check("lu.rs1",        ifid_rs1,      32'd5);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
    tick("lu_resume");
    check("lu.clear_mr", indec_memread, 1'b0);
    check("lu.add_rd",   indec_rd,      32'd6);
    check("lu.add_v",    indec_valid,   1'b1);
    use_ovr = 1'b0;

    // Flush beats stall
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1);
    branch_target = 32'h100;
    tick("flush_stall");
    check("fl.pc",    pc_out,      32'h100);
    check("fl.iv",    ifid_valid,  1'b0);
    check("fl.rs1",   ifid_rs1,    32'h0);
    check("fl.rs2",   ifid_rs2,    32'h0);
    check("fl.ev",    indec_valid, 1'b0);
    check("fl.cnt",   stall_count, 32'd1);

    // PC wrap at top of address space
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
    branch_target = 32'hFFFF_FFFC;
    tick("wrap_redirect");
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
    tick("wrap_step");
    check("wrap.pc", pc_out, 32'h0);

    // Counter saturation on the 2-bit instance
    async_reset("sat_rst");
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick("sat");
    check("sat.narrow", s_stall_count, 32'd3);
    check("sat.wide",   stall_count,   32'd5);

    // Reset arriving during a stall; fetch must restart at RESET_PC
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
    tick("pre_stall0");
    tick("pre_stall1");
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
    tick("mid_stall");
    async_reset("stall_rst");
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
    tick("restart");
    check("restart.pc",      pc_out,     32'h4);
    check("restart.ifid_pc", ifid_pc,    32'h0);
    check("restart.iv",      ifid_valid, 1'b1);

    // Random control mix against the model
    for (int i = 0; i < 300; i++) begin
      set_ctl($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
      r = $urandom;
      branch_target = r & 32'hFFFF_FFFC;
      id_rd = 5'($urandom_range(0, 31));
      id_memread  = 1'($urandom_range(0, 1));
      id_memwrite = 1'($urandom_range(0, 1));
      id_regwrite = 1'($urandom_range(0, 1));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
